// File: rtl/pm1_seq_ctrl.sv
// pm1_seq_ctrl: round-robin sequencer that shares one pm1 combinational
// evaluator among NREQ requesters. A granted operand is registered onto the
// evaluator input, held for SETTLE cycles, and the captured result is returned
// with the requester ID over a valid/ready response channel.
module pm1_seq_ctrl #(
    parameter int NREQ   = 4,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 13,
    parameter int SETTLE = 1,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk_pad,
    input  logic                 rst_pad,
    input  logic [NREQ-1:0]      req_valid_pad,
    input  logic [NREQ*IN_W-1:0] req_data_pad,
    output logic [NREQ-1:0]      req_ready_pad,
    output logic [IN_W-1:0]      dp_in_pad,
    input  logic [OUT_W-1:0]     dp_out_pad,
    output logic                 rsp_valid_pad,
    input  logic                 rsp_ready_pad,
    output logic [OUT_W-1:0]     rsp_data_pad,
    output logic [ID_W-1:0]      rsp_id_pad,
    output logic                 busy_pad,
    output logic [7:0]           txn_cnt_pad
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETTLE = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [IN_W-1:0]    op_r;
    logic [OUT_W-1:0]   res_r;
    logic [ID_W-1:0]    id_r;
    logic [ID_W-1:0]    last_grant_r;
    logic [3:0]         cnt_r;
    logic [7:0]         txn_cnt_r;

    logic               found_s;
    logic [ID_W-1:0]    win_s;
    logic [ID_W-1:0]    cand_s;
    logic [ID_W:0]      sum_s;
    logic               transfer_s;
    logic               capture_s;
    logic               count_down_s;
    logic               handshake_s;

    // Round-robin search: first valid requester after the last grant, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        cand_s  = '0;
        sum_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum_s = {1'b0, last_grant_r} + (ID_W+1)'(k);
            if (sum_s >= (ID_W+1)'(NREQ)) begin
                sum_s = sum_s - (ID_W+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[ID_W-1:0];
            if (!found_s && (|(req_valid_pad & (NREQ'(1) << cand_s)))) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_nxt_s   = state_r;
        req_ready_pad = '0;
        transfer_s    = 1'b0;
        capture_s     = 1'b0;
        count_down_s  = 1'b0;
        handshake_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (found_s) begin
                    req_ready_pad = NREQ'(1) << win_s;
                    transfer_s    = 1'b1;
                    state_nxt_s   = S_SETTLE;
                end else begin
                    state_nxt_s   = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (cnt_r == 4'd0) begin
                    capture_s    = 1'b1;
                    state_nxt_s  = S_RESP;
                end else begin
                    count_down_s = 1'b1;
                    state_nxt_s  = S_SETTLE;
                end
            end
            S_RESP: begin
                if (rsp_ready_pad) begin
                    handshake_s = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register; reset always returns to IDLE, abandoning any transaction.
    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand/result/ID capture, settle counter and completed-transaction count.
    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            op_r         <= '0;
            res_r        <= '0;
            id_r         <= '0;
            last_grant_r <= ID_W'(NREQ - 1);
            cnt_r        <= 4'd0;
            txn_cnt_r    <= 8'd0;
        end else begin
            if (transfer_s) begin
                op_r         <= req_data_pad[win_s*IN_W +: IN_W];
                id_r         <= win_s;
                last_grant_r <= win_s;
                cnt_r        <= 4'(SETTLE - 1);
            end else if (count_down_s) begin
                cnt_r        <= cnt_r - 4'd1;
            end
            if (capture_s) begin
                res_r <= dp_out_pad;
            end
            if (handshake_s) begin
                txn_cnt_r <= txn_cnt_r + 8'd1;
            end
        end
    end

    // Outputs come straight from registers (state decode for valid/busy).
    assign dp_in_pad     = op_r;
    assign rsp_valid_pad = (state_r == S_RESP);
    assign rsp_data_pad  = res_r;
    assign rsp_id_pad    = id_r;
    assign busy_pad      = (state_r != S_IDLE);
    assign txn_cnt_pad   = txn_cnt_r;

endmodule

// File: tb/tb_pm1_seq_ctrl.sv
// Directed testbench for pm1_seq_ctrl: one instance with SETTLE=1 and a
// zero-delay evaluator, one with SETTLE=3 and an evaluator that settles two
// cycles after its input changes.
module tb_pm1_seq_ctrl;

    logic        clk;
    logic        rst;

    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [15:0] dp_in;
    logic [12:0] dp_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [12:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [7:0]  txn_cnt;

    logic [3:0]  req_valid3;
    logic [63:0] req_data3;
    logic [3:0]  req_ready3;
    logic [15:0] dp_in3;
    logic [12:0] dp_out3;
    logic        rsp_valid3;
    logic        rsp_ready3;
    logic [12:0] rsp_data3;
    logic [1:0]  rsp_id3;
    logic        busy3;
    logic [7:0]  txn_cnt3;

    logic [15:0] d1;
    logic [15:0] d2;

    int vectors = 0;
    int errs    = 0;

    function automatic logic [12:0] pm1_model(input logic [15:0] x);
        return x[12:0] ^ x[15:3] ^ 13'h00A5;
    endfunction

    assign dp_out  = pm1_model(dp_in);
    assign dp_out3 = pm1_model(d2);

    pm1_seq_ctrl #(.NREQ(4), .IN_W(16), .OUT_W(13), .SETTLE(1)) dut (
        .clk_pad(clk), .rst_pad(rst),
        .req_valid_pad(req_valid), .req_data_pad(req_data), .req_ready_pad(req_ready),
        .dp_in_pad(dp_in), .dp_out_pad(dp_out),
        .rsp_valid_pad(rsp_valid), .rsp_ready_pad(rsp_ready),
        .rsp_data_pad(rsp_data), .rsp_id_pad(rsp_id),
        .busy_pad(busy), .txn_cnt_pad(txn_cnt)
    );

    pm1_seq_ctrl #(.NREQ(4), .IN_W(16), .OUT_W(13), .SETTLE(3)) dut3 (
        .clk_pad(clk), .rst_pad(rst),
        .req_valid_pad(req_valid3), .req_data_pad(req_data3), .req_ready_pad(req_ready3),
        .dp_in_pad(dp_in3), .dp_out_pad(dp_out3),
        .rsp_valid_pad(rsp_valid3), .rsp_ready_pad(rsp_ready3),
        .rsp_data_pad(rsp_data3), .rsp_id_pad(rsp_id3),
        .busy_pad(busy3), .txn_cnt_pad(txn_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slow evaluator for the SETTLE=3 instance: output follows input two cycles late.
    always @(posedge clk) begin
        if (rst) begin
            d1 <= 16'h0000;
            d2 <= 16'h0000;
        end else begin
            d1 <= dp_in3;
            d2 <= d1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  exp_id;
        logic [15:0] exp_op;

        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_data   = 64'h0;
        rsp_ready  = 1'b0;
        req_valid3 = 4'b0000;
        req_data3  = 64'h0;
        rsp_ready3 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_dp_in", dp_in, 16'h0000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_txn", txn_cnt, 8'd0);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_rsp_data", rsp_data, 13'h0000);

        // Single request from requester 2
        req_valid = 4'b0100;
        req_data[2*16 +: 16] = 16'hA5C3;
        rsp_ready = 1'b1;
        #1;
        chk("t1_ready_c0", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("t1_dp_in_c1", dp_in, 16'hA5C3);
        chk("t1_busy_c1", busy, 1'b1);
        chk("t1_valid_c1", rsp_valid, 1'b0);
        tick();
        #1;
        chk("t1_valid_c2", rsp_valid, 1'b1);
        chk("t1_id_c2", rsp_id, 2'd2);
        chk("t1_data_c2", rsp_data, 13'h11DE);
        tick();
        #1;
        chk("t1_busy_c3", busy, 1'b0);
        chk("t1_txn", txn_cnt, 8'd1);
        chk("t1_dp_in_hold", dp_in, 16'hA5C3);

        // Round-robin with all four requesters valid, from reset priority
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 4; i++) begin
                req_data[i*16 +: 16] = 16'h3C00 + 16'(t*16 + i);
            end
            exp_id = 2'(t % 4);
            exp_op = req_data[exp_id*16 +: 16];
            #1;
            chk("rr_grant", req_ready, 4'b0001 << exp_id);
            tick();
            #1;
            chk("rr_dp_in", dp_in, exp_op);
            tick();
            #1;
            chk("rr_rsp_id", rsp_id, exp_id);
            chk("rr_rsp_data", rsp_data, pm1_model(exp_op));
            tick();
        end
        #1;
        chk("rr_txn", txn_cnt, 8'd8);

        // Backpressure: requester 1, five stall cycles in RESP
        req_valid = 4'b0010;
        req_data[1*16 +: 16] = 16'hBEEF;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1111;
        #1;
        chk("bp_ready_settle", req_ready, 4'b0000);
        tick();
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_data", rsp_data, pm1_model(16'hBEEF));
            chk("bp_id", rsp_id, 2'd1);
            chk("bp_ready", req_ready, 4'b0000);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_valid_hs", rsp_valid, 1'b1);
        chk("bp_ready_hs", req_ready, 4'b0000);
        tick();
        #1;
        chk("bp_busy_after", busy, 1'b0);
        chk("bp_valid_after", rsp_valid, 1'b0);
        chk("bp_txn", txn_cnt, 8'd9);
        chk("bp_next_grant", req_ready, 4'b0100);
        req_valid = 4'b0000;

        // SETTLE=3 instance with slow evaluator
        req_valid3 = 4'b0001;
        req_data3[0 +: 16] = 16'hC0DE;
        rsp_ready3 = 1'b1;
        #1;
        chk("s3_grant", req_ready3, 4'b0001);
        tick();
        req_valid3 = 4'b0000;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("s3_no_valid", rsp_valid3, 1'b0);
            tick();
        end
        #1;
        chk("s3_valid_c4", rsp_valid3, 1'b1);
        chk("s3_data", rsp_data3, pm1_model(16'hC0DE));
        chk("s3_id", rsp_id3, 2'd0);
        tick();
        #1;
        chk("s3_busy_after", busy3, 1'b0);
        chk("s3_txn", txn_cnt3, 8'd1);

        // Reset pulse during SETTLE
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        chk("ab_grant", req_ready, 4'b0100);
        tick();
        rst = 1'b1;
        #1;
        chk("ab_busy_settle", busy, 1'b1);
        tick();
        rst = 1'b0;
        #1;
        chk("ab_busy", busy, 1'b0);
        chk("ab_dp_in", dp_in, 16'h0000);
        chk("ab_txn", txn_cnt, 8'd0);
        chk("ab_valid", rsp_valid, 1'b0);
        chk("ab_next_grant", req_ready, 4'b0001);
        req_valid = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            chk("ab_no_rsp", rsp_valid, 1'b0);
        end

        // Transaction counter wrap with requester 3 back-to-back
        req_valid = 4'b1000;
        req_data[3*16 +: 16] = 16'h7777;
        rsp_ready = 1'b1;
        for (int n = 1; n <= 257; n++) begin
            tick();
            tick();
            tick();
            if (n == 255) chk("wrap_255", txn_cnt, 8'd255);
            if (n == 256) chk("wrap_256", txn_cnt, 8'd0);
            if (n == 257) chk("wrap_257", txn_cnt, 8'd1);
        end
        req_valid = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
